// File: rtl/mm_feed_scheduler.sv
// Operand feed scheduler for the matrix-multiply top: walks the (i, j, n, ii) tile loop nest,
// reads A/B SRAMs and streams the returned words through a 2-entry skid buffer.
module mm_feed_scheduler #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned A_NUM_WIDTH = 3,
    parameter int unsigned B_NUM_WIDTH = 3,
    parameter int unsigned N_MAX_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_MAX_WIDTH-1:0] N_in,
    output logic [ADDR_WIDTH-1:0]  A_addr,
    output logic [ADDR_WIDTH-1:0]  B_addr,
    output logic                   rd_en,
    input  logic [DATA_WIDTH-1:0]  A_rdata,
    input  logic [DATA_WIDTH-1:0]  B_rdata,
    output logic [DATA_WIDTH-1:0]  A_out,
    output logic [DATA_WIDTH-1:0]  B_out,
    output logic                   AB_valid,
    input  logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    if (B_NUM_WIDTH != A_NUM_WIDTH) begin : g_tile_check
        $error("mm_feed_scheduler: B_NUM_WIDTH must equal A_NUM_WIDTH");
    end
    if (A_NUM_WIDTH == 0) begin : g_tile_nonzero
        $error("mm_feed_scheduler: A_NUM_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state, state_nx;
    logic [N_MAX_WIDTH-1:0]  n_reg, n_reg_nx;
    logic [N_MAX_WIDTH-1:0]  i_cnt, i_nx;
    logic [N_MAX_WIDTH-1:0]  j_cnt, j_nx;
    logic [N_MAX_WIDTH-1:0]  n_cnt, n_nx;
    logic [A_NUM_WIDTH-1:0]  ii_cnt, ii_nx;
    logic [ADDR_WIDTH-1:0]   a_addr_q, a_addr_nx;
    logic [ADDR_WIDTH-1:0]   b_addr_q, b_addr_nx;
    logic                    busy_q, busy_nx;
    logic                    done_q, done_nx;
    logic                    err_q, err_nx;

    // Skid buffer: entry 0 is the head presented downstream
    logic [DATA_WIDTH-1:0]   buf_a0, buf_a1, buf_b0, buf_b1;
    logic [DATA_WIDTH-1:0]   buf_a0_nx, buf_a1_nx, buf_b0_nx, buf_b1_nx;
    logic [1:0]              cnt, cnt_nx;
    logic                    valid_q, valid_nx;
    logic                    inflight;

    logic                    n_ok;
    logic                    pop;
    logic [2:0]              occ;
    logic                    can_issue;
    logic                    issue;
    logic [N_MAX_WIDTH-1:0]  n_eff;
    logic [N_MAX_WIDTH-1:0]  tiles;
    logic                    wrap_ii, wrap_n, wrap_j, last;
    logic [ADDR_WIDTH-1:0]   a_row;

    assign n_ok  = (N_in != '0) && (N_in[A_NUM_WIDTH-1:0] == '0);
    assign pop   = valid_q && ready;

    // Occupancy the buffer will have after this edge; a read issued now lands one edge later
    assign occ       = 3'(cnt) + 3'(inflight) - 3'(pop);
    assign can_issue = (occ < 3'd2);

    // The start cycle already issues beat 0, so N comes straight from N_in while idle
    assign n_eff = (state == S_IDLE) ? N_in : n_reg;
    assign tiles = n_eff >> A_NUM_WIDTH;

    assign wrap_ii = (ii_cnt == '1);
    assign wrap_n  = wrap_ii && (n_cnt == n_eff - N_MAX_WIDTH'(1));
    assign wrap_j  = wrap_n && (j_cnt == tiles - N_MAX_WIDTH'(1));
    assign last    = wrap_j && (i_cnt == tiles - N_MAX_WIDTH'(1));

    assign issue = ((state == S_RUN) || ((state == S_IDLE) && start && n_ok)) && can_issue;

    // Loop-nest counters and the addresses of the next read to issue
    always_comb begin
        ii_nx = ii_cnt + A_NUM_WIDTH'(1);
        n_nx  = n_cnt;
        j_nx  = j_cnt;
        i_nx  = i_cnt;
        if (wrap_ii) begin
            n_nx = wrap_n ? '0 : n_cnt + N_MAX_WIDTH'(1);
        end
        if (wrap_n) begin
            j_nx = wrap_j ? '0 : j_cnt + N_MAX_WIDTH'(1);
        end
        if (wrap_j) begin
            i_nx = last ? '0 : i_cnt + N_MAX_WIDTH'(1);
        end
        a_row     = (ADDR_WIDTH'(i_nx) << A_NUM_WIDTH) + ADDR_WIDTH'(ii_nx);
        a_addr_nx = a_row * ADDR_WIDTH'(n_eff) + ADDR_WIDTH'(n_nx);
        b_addr_nx = ADDR_WIDTH'(n_nx) * ADDR_WIDTH'(n_eff)
                  + (ADDR_WIDTH'(j_nx) << B_NUM_WIDTH) + ADDR_WIDTH'(ii_nx);
    end

    // Next-state and control
    always_comb begin
        state_nx = state;
        n_reg_nx = n_reg;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (n_ok) begin
                        n_reg_nx = N_in;
                        state_nx = (issue && last) ? S_DRAIN : S_RUN;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (issue && last) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (occ == 3'd0) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

    // Skid buffer push (data returned for last cycle's read) and pop
    always_comb begin
        buf_a0_nx = buf_a0;
        buf_a1_nx = buf_a1;
        buf_b0_nx = buf_b0;
        buf_b1_nx = buf_b1;
        cnt_nx    = cnt;
        case ({inflight, pop})
            2'b10: begin
                if (cnt == 2'd0) begin
                    buf_a0_nx = A_rdata;
                    buf_b0_nx = B_rdata;
                end else begin
                    buf_a1_nx = A_rdata;
                    buf_b1_nx = B_rdata;
                end
                cnt_nx = cnt + 2'd1;
            end
            2'b01: begin
                buf_a0_nx = buf_a1;
                buf_b0_nx = buf_b1;
                cnt_nx    = cnt - 2'd1;
            end
            2'b11: begin
                if (cnt == 2'd1) begin
                    buf_a0_nx = A_rdata;
                    buf_b0_nx = B_rdata;
                end else begin
                    buf_a0_nx = buf_a1;
                    buf_b0_nx = buf_b1;
                    buf_a1_nx = A_rdata;
                    buf_b1_nx = B_rdata;
                end
            end
            default: ;
        endcase
        valid_nx = (cnt_nx != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            n_reg    <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            n_cnt    <= '0;
            ii_cnt   <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            buf_a0   <= '0;
            buf_a1   <= '0;
            buf_b0   <= '0;
            buf_b1   <= '0;
            cnt      <= 2'd0;
            valid_q  <= 1'b0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nx;
            n_reg    <= n_reg_nx;
            busy_q   <= busy_nx;
            done_q   <= done_nx;
            err_q    <= err_nx;
            buf_a0   <= buf_a0_nx;
            buf_a1   <= buf_a1_nx;
            buf_b0   <= buf_b0_nx;
            buf_b1   <= buf_b1_nx;
            cnt      <= cnt_nx;
            valid_q  <= valid_nx;
            inflight <= issue;
            if (issue) begin
                i_cnt    <= i_nx;
                j_cnt    <= j_nx;
                n_cnt    <= n_nx;
                ii_cnt   <= ii_nx;
                a_addr_q <= a_addr_nx;
                b_addr_q <= b_addr_nx;
            end
        end
    end

    assign rd_en    = issue;
    assign A_addr   = a_addr_q;
    assign B_addr   = b_addr_q;
    assign A_out    = buf_a0;
    assign B_out    = buf_b0;
    assign AB_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
